// File: rtl/clock_set_ctrl_pkg.sv
// Shared mode encoding for the clock time-setting controller.
package clock_set_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:     return MODE_SET_HR;
      MODE_SET_HR:  return MODE_SET_MIN;
      MODE_SET_MIN: return MODE_SET_SEC;
      default:      return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button levels and ms strobe in, mode/pulse/blink controls out.
interface clock_set_ctrl_if;
  import clock_set_pkg::*;

  logic  tick_ms;
  logic  mode_lvl;
  logic  inc_lvl;
  logic  dec_lvl;
  mode_t mode;
  logic  run_en;
  logic  inc_pulse;
  logic  dec_pulse;
  logic  blink;

  modport master (
    output tick_ms, mode_lvl, inc_lvl, dec_lvl,
    input  mode, run_en, inc_pulse, dec_pulse, blink
  );

  modport slave (
    input  tick_ms, mode_lvl, inc_lvl, dec_lvl,
    output mode, run_en, inc_pulse, dec_pulse, blink
  );
endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Press-edge detector with long-press auto-repeat; pulse is the unregistered
// request, the parent registers it.
module btn_repeat #(
  parameter logic PRESS_LVL = 1'b0,
  parameter int   HOLD_MS   = 1000,
  parameter int   REPEAT_MS = 200,
  parameter int   CW        = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic level,
  input  logic enable,
  input  logic cancel,
  output logic held,
  output logic press_edge,
  output logic pulse
);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT_MS - 1);

  logic          lvl_q, prev_q;
  logic          active_q, active_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign held       = (lvl_q == PRESS_LVL);
  assign press_edge = held && (prev_q != PRESS_LVL);

  always_comb begin
    active_d = active_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    pulse    = 1'b0;
    if (!held || cancel) begin
      // Cancel drops the repeat entirely: only a fresh press edge re-arms it.
      active_d = 1'b0;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (press_edge) begin
      active_d = enable;
      pulse    = enable;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (active_q && tick_ms) begin
      if (cnt_q == (rep_q ? REP_END : HOLD_END)) begin
        pulse = 1'b1;
        rep_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q    <= ~PRESS_LVL;
      prev_q   <= ~PRESS_LVL;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      lvl_q    <= level;
      prev_q   <= lvl_q;
      active_q <= active_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode sequencing, SET-mode timeout, blink, and
// registered inc/dec pulses from two auto-repeat button channels.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter logic PRESS_LVL  = 1'b0,
  parameter int   HOLD_MS    = 1000,
  parameter int   REPEAT_MS  = 200,
  parameter int   TIMEOUT_MS = 10000,
  parameter int   BLINK_MS   = 500,
  parameter int   CW         = 14
) (
  input logic            clk,
  input logic            rst_n,
  clock_set_ctrl_if.slave bus
);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT_MS - 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_MS);
  localparam logic [CW-1:0] BL_END = CW'(BLINK_MS - 1);

  logic          mlvl_q, mprev_q;
  mode_t         mode_q, mode_d;
  logic          run_en_q, run_en_d;
  logic          inc_pulse_q, inc_pulse_d;
  logic          dec_pulse_q, dec_pulse_d;
  logic          blink_q, blink_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [CW-1:0] bcnt_q, bcnt_d;

  logic       mode_edge, in_set, any_edge, mode_chg, cancel;
  logic [1:0] btn_lvl, btn_held, btn_edge, btn_pulse;

  assign btn_lvl   = {bus.dec_lvl, bus.inc_lvl};
  assign mode_edge = (mlvl_q == PRESS_LVL) && (mprev_q != PRESS_LVL);
  assign in_set    = (mode_q != MODE_RUN);

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_repeat #(
      .PRESS_LVL (PRESS_LVL),
      .HOLD_MS   (HOLD_MS),
      .REPEAT_MS (REPEAT_MS),
      .CW        (CW)
    ) u_btn (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_ms    (bus.tick_ms),
      .level      (btn_lvl[gi]),
      .enable     (in_set),
      .cancel     (cancel),
      .held       (btn_held[gi]),
      .press_edge (btn_edge[gi]),
      .pulse      (btn_pulse[gi])
    );
  end

  // Mode and idle timeout; a MODE edge wins over everything else this cycle.
  always_comb begin
    any_edge = mode_edge | (|btn_edge);
    mode_d   = mode_q;
    idle_d   = idle_q;
    if (mode_edge) begin
      mode_d = next_mode(mode_q);
    end else if (in_set && bus.tick_ms && !any_edge && idle_q == TO_END) begin
      mode_d = MODE_RUN;
    end
    if (!in_set || any_edge) begin
      idle_d = '0;
    end else if (bus.tick_ms && idle_q != TO_MAX) begin
      idle_d = idle_q + CW'(1);
    end
    mode_chg = (mode_d != mode_q);
    cancel   = mode_chg || (&btn_held);
    run_en_d = (mode_d == MODE_RUN);
  end

  always_comb begin
    inc_pulse_d = btn_pulse[0];
    dec_pulse_d = btn_pulse[1];
    blink_d     = blink_q;
    bcnt_d      = bcnt_q;
    if (mode_d == MODE_RUN || mode_chg || (|btn_pulse)) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bus.tick_ms) begin
      if (bcnt_q == BL_END) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlvl_q      <= ~PRESS_LVL;
      mprev_q     <= ~PRESS_LVL;
      mode_q      <= MODE_RUN;
      run_en_q    <= 1'b1;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      blink_q     <= 1'b1;
      idle_q      <= '0;
      bcnt_q      <= '0;
    end else begin
      mlvl_q      <= bus.mode_lvl;
      mprev_q     <= mlvl_q;
      mode_q      <= mode_d;
      run_en_q    <= run_en_d;
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      blink_q     <= blink_d;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.run_en    = run_en_q;
  assign bus.inc_pulse = inc_pulse_q;
  assign bus.dec_pulse = dec_pulse_q;
  assign bus.blink     = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected mode/pulse
// events with their cycle, a negedge monitor pops and compares them.
module tb_clock_set_ctrl;
  localparam int EV_MODE = 0;
  localparam int EV_INC  = 1;
  localparam int EV_DEC  = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   last_mode = 0;
  ev_t  exp_q[$];

  clock_set_ctrl_if bif ();

  clock_set_ctrl #(
    .HOLD_MS    (4),
    .REPEAT_MS  (2),
    .TIMEOUT_MS (20),
    .BLINK_MS   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-clock ms strobe every 4 clocks, seen by the DUT on edges where cyc%4==0.
  initial begin
    bif.tick_ms = 1'b0;
    forever begin
      @(negedge clk);
      bif.tick_ms = (cyc % 4 == 3);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int k, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: got kind=%0d val=%0d cyc=%0d, expected no event", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.val == v && (e.cyc < 0 || e.cyc == cyc)) begin
        passed++;
        $display("event kind=%0d val=%0d cyc=%0d ok", k, v, cyc);
      end else begin
        $display("FAIL sb_event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bif.inc_pulse && bif.dec_pulse) begin
      total++;
      $display("FAIL pulse_excl: got inc=1 dec=1, expected at most one (cyc %0d)", cyc);
    end
    if (bif.inc_pulse) sb_check(EV_INC, 1);
    if (bif.dec_pulse) sb_check(EV_DEC, 1);
    if (int'(bif.mode) != last_mode) begin
      sb_check(EV_MODE, int'(bif.mode));
      chk("run_en_on_mode", int'(bif.run_en), (int'(bif.mode) == 0) ? 1 : 0);
      last_mode = int'(bif.mode);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_phase(input int r);
    do @(negedge clk); while (cyc % 4 != r);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press_mode(input int exp_mode);
    int d;
    d = cyc;
    bif.mode_lvl = 1'b0;
    expect_ev(EV_MODE, exp_mode, d + 2);
    step(2);
    chk("mode_run_en", int'(bif.run_en), (exp_mode == 0) ? 1 : 0);
    step(1);
    bif.mode_lvl = 1'b1;
    step(3);
  endtask

  initial begin
    int d;
    rst_n        = 1'b0;
    bif.mode_lvl = 1'b1;
    bif.inc_lvl  = 1'b1;
    bif.dec_lvl  = 1'b1;
    step(4);
    rst_n = 1'b1;
    chk("rst_mode", int'(bif.mode), 0);
    chk("rst_run_en", int'(bif.run_en), 1);
    chk("rst_inc", int'(bif.inc_pulse), 0);
    chk("rst_dec", int'(bif.dec_pulse), 0);
    chk("rst_blink", int'(bif.blink), 1);
    step(2);

    // INC in RUN is ignored
    bif.inc_lvl = 1'b0;
    step(2);
    chk("run_inc_no_pulse", int'(bif.inc_pulse), 0);
    step(10);
    bif.inc_lvl = 1'b1;
    step(4);

    // Full mode cycle
    press_mode(1);
    press_mode(2);
    press_mode(3);
    press_mode(0);

    // SET_HR: hold INC 10 ticks -> pulses at press, ticks 4,6,8,10
    press_mode(1);
    to_phase(1);
    d = cyc;
    bif.inc_lvl = 1'b0;
    expect_ev(EV_INC, 1, d + 2);
    expect_ev(EV_INC, 1, d + 15);
    expect_ev(EV_INC, 1, d + 23);
    expect_ev(EV_INC, 1, d + 31);
    expect_ev(EV_INC, 1, d + 39);
    wait_until(d + 14);
    chk("blink_toggled", int'(bif.blink), 0);
    wait_until(d + 15);
    chk("blink_restart_on_pulse", int'(bif.blink), 1);
    wait_until(d + 39);
    bif.inc_lvl = 1'b1;
    wait_until(d + 50);
    chk("blink_before_3rd_tick", int'(bif.blink), 1);
    wait_until(d + 51);
    chk("blink_after_3rd_tick", int'(bif.blink), 0);

    // INC+DEC together, then DEC released while INC still held
    to_phase(1);
    bif.inc_lvl = 1'b0;
    bif.dec_lvl = 1'b0;
    step(12);
    bif.dec_lvl = 1'b1;
    step(20);
    bif.inc_lvl = 1'b1;
    step(4);
    to_phase(1);
    d = cyc;
    bif.inc_lvl = 1'b0;
    expect_ev(EV_INC, 1, d + 2);
    step(3);
    bif.inc_lvl = 1'b1;
    step(6);

    // DEC pressed while INC held kills the repeat
    to_phase(1);
    d = cyc;
    bif.inc_lvl = 1'b0;
    expect_ev(EV_INC, 1, d + 2);
    step(4);
    bif.dec_lvl = 1'b0;
    step(24);
    bif.inc_lvl = 1'b1;
    bif.dec_lvl = 1'b1;
    step(6);

    // MODE beats same-cycle INC; then SET_MIN times out after 20 ticks
    to_phase(1);
    d = cyc;
    bif.mode_lvl = 1'b0;
    bif.inc_lvl  = 1'b0;
    expect_ev(EV_MODE, 2, d + 2);
    expect_ev(EV_MODE, 0, d + 79);
    step(3);
    bif.mode_lvl = 1'b1;
    bif.inc_lvl  = 1'b1;
    wait_until(d + 78);
    chk("setmin_before_timeout", int'(bif.mode), 2);
    wait_until(d + 84);

    // DEC press just after tick 19 restarts the timeout
    press_mode(1);
    to_phase(1);
    d = cyc;
    press_mode(2);
    expect_ev(EV_DEC, 1, d + 76);
    expect_ev(EV_MODE, 0, d + 155);
    wait_until(d + 74);
    bif.dec_lvl = 1'b0;
    step(3);
    bif.dec_lvl = 1'b1;
    wait_until(d + 154);
    chk("setmin_extended", int'(bif.mode), 2);
    wait_until(d + 160);

    // Reset mid-repeat in SET_SEC
    press_mode(1);
    press_mode(2);
    press_mode(3);
    to_phase(1);
    d = cyc;
    bif.inc_lvl = 1'b0;
    expect_ev(EV_INC, 1, d + 2);
    expect_ev(EV_INC, 1, d + 15);
    expect_ev(EV_INC, 1, d + 23);
    wait_until(d + 25);
    expect_ev(EV_MODE, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mode", int'(bif.mode), 0);
    chk("midrst_run_en", int'(bif.run_en), 1);
    chk("midrst_inc", int'(bif.inc_pulse), 0);
    chk("midrst_blink", int'(bif.blink), 1);
    step(3);
    rst_n = 1'b1;
    step(30);
    chk("post_rst_mode", int'(bif.mode), 0);
    bif.inc_lvl = 1'b1;
    step(8);

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
